// File: rtl/outer_loop_seq_78.sv
// Outer-loop sequencer for the radix-78 multi-precision multiplier: latches operand B,
// issues one inner-loop enable per digit, waits for completion and hands results off.
module outer_loop_seq_78 #(
    parameter int Size    = 3072,
    parameter int radix   = 78,
    parameter int DIGITS  = 40,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [Size-1:0]   b,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              il_en,
    output logic [radix-1:0]  il_bi,
    input  logic              il_en_out,
    output logic              acc_valid,
    output logic [5:0]        acc_idx,
    input  logic              acc_ready
);

    localparam int EXT_W = DIGITS * radix;
    localparam int WC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACC   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [Size-1:0]   b_r;
    logic [5:0]        k_r;
    logic [WC_W-1:0]   wcnt_r;
    logic              err_r;
    logic [radix-1:0]  bi_r;

    // The top digit is short; zero-padding the operand lets every digit use the same slice.
    function automatic logic [radix-1:0] digit_of(input logic [Size-1:0] vec, input logic [5:0] idx);
        logic [EXT_W-1:0] ext;
        ext = {{(EXT_W-Size){1'b0}}, vec};
        return ext[idx*radix +: radix];
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort overrides every other event
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) state_s = S_ISSUE;
                    else       state_s = S_IDLE;
                end
                S_ISSUE: state_s = S_WAIT;
                S_WAIT: begin
                    if (il_en_out)                             state_s = S_ACC;
                    else if (wcnt_r == WC_W'(TIMEOUT - 1))     state_s = S_IDLE;
                    else                                       state_s = S_WAIT;
                end
                S_ACC: begin
                    if (acc_ready) begin
                        if (k_r == 6'(DIGITS - 1)) state_s = S_DONE;
                        else                       state_s = S_ISSUE;
                    end else begin
                        state_s = S_ACC;
                    end
                end
                S_DONE:  state_s = S_IDLE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Operand, digit counter, wait counter, sticky error and current-digit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_r    <= {Size{1'b0}};
            k_r    <= 6'd0;
            wcnt_r <= {WC_W{1'b0}};
            err_r  <= 1'b0;
            bi_r   <= {radix{1'b0}};
        end else if (!abort) begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        b_r   <= b;
                        k_r   <= 6'd0;
                        err_r <= 1'b0;
                        bi_r  <= digit_of(b, 6'd0);
                    end
                end
                S_ISSUE: wcnt_r <= {WC_W{1'b0}};
                S_WAIT: begin
                    if (!il_en_out) begin
                        if (wcnt_r == WC_W'(TIMEOUT - 1)) err_r  <= 1'b1;
                        else                              wcnt_r <= wcnt_r + {{(WC_W-1){1'b0}}, 1'b1};
                    end
                end
                S_ACC: begin
                    // il_bi only changes on the way into ISSUE, never while a digit is in use
                    if (acc_ready && (k_r != 6'(DIGITS - 1))) begin
                        k_r  <= k_r + 6'd1;
                        bi_r <= digit_of(b_r, k_r + 6'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the registered state only
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        il_en     = 1'b0;
        acc_valid = 1'b0;
        case (state_r)
            S_ISSUE: begin busy = 1'b1; il_en = 1'b1; end
            S_WAIT:  begin busy = 1'b1; end
            S_ACC:   begin busy = 1'b1; acc_valid = 1'b1; end
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    assign il_bi   = bi_r;
    assign err     = err_r;
    assign acc_idx = k_r;

endmodule

// File: tb/tb_outer_loop_seq_78.sv
// Bench for outer_loop_seq_78: behavioural inner loop and accumulator, random operands,
// expected schedule derived from the per-digit cycle cost.
module tb_outer_loop_seq_78;

    localparam int SZ = 3072;
    localparam int RX = 78;
    localparam int ND = 40;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [SZ-1:0]   b = '0;
    logic            abort = 1'b0;
    logic            busy, done, err, il_en, acc_valid;
    logic [RX-1:0]   il_bi;
    logic            il_en_out = 1'b0;
    logic [5:0]      acc_idx;
    logic            acc_ready = 1'b0;

    outer_loop_seq_78 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .b(b), .abort(abort),
        .busy(busy), .done(done), .err(err), .il_en(il_en), .il_bi(il_bi),
        .il_en_out(il_en_out), .acc_valid(acc_valid), .acc_idx(acc_idx), .acc_ready(acc_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [SZ-1:0] b_v = '0;
    bit start_v = 1'b0, abort_v = 1'b0, start_on_idle = 1'b0, spur_on = 1'b0;
    int cyc, idle_cyc, last_en, bi_glitch, overlap, il_pend = 0;
    int hang_digit = -1, slow_digit = -1, stall_digit = -1, stall_left = 0;
    int en_cyc[$];
    logic [RX-1:0] en_bi[$];
    int acc_q[$];
    int done_cyc[$];
    int acc_hold[64];
    bit prev_busy = 1'b0;
    logic [RX-1:0] prev_bi = '0;

    function automatic logic [SZ-1:0] rand_b();
        logic [SZ-1:0] v;
        for (int i = 0; i < SZ/32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [RX-1:0] exp_digit(input logic [SZ-1:0] bv, input int k);
        logic [SZ-1:0] s;
        s = bv >> (k * RX);
        return s[RX-1:0];
    endfunction

    task automatic clear_rec();
        en_cyc.delete(); en_bi.delete(); acc_q.delete(); done_cyc.delete();
        for (int i = 0; i < 64; i++) acc_hold[i] = 0;
        idle_cyc = -1; last_en = -100; bi_glitch = 0; overlap = 0;
    endtask

    // One clock cycle: observe outputs, play inner loop and accumulator, drive inputs.
    task automatic tick();
        bit rdy, eo;
        @(negedge clk);
        if (il_en) begin
            if (cyc - last_en < 5) overlap++;
            last_en = cyc;
            en_cyc.push_back(cyc);
            en_bi.push_back(il_bi);
        end
        if (done) done_cyc.push_back(cyc);
        if (prev_busy && !busy && idle_cyc < 0) idle_cyc = cyc;
        if (busy && prev_busy && !il_en && il_bi !== prev_bi) bi_glitch++;
        eo = 1'b0;
        if (il_pend > 0) begin
            il_pend--;
            if (il_pend == 0) eo = 1'b1;
        end
        if (il_en && (en_cyc.size() - 1) != hang_digit)
            il_pend = ((en_cyc.size() - 1) == slow_digit) ? 8 : 4;
        rdy = 1'b1;
        if (acc_valid && acc_idx == stall_digit && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end
        if (acc_valid) acc_hold[acc_idx]++;
        if (acc_valid && rdy) acc_q.push_back(int'(acc_idx));
        if (acc_valid && spur_on) eo = 1'b1;
        start = start_v || (start_on_idle && prev_busy && !busy);
        abort = abort_v;
        b = b_v;
        il_en_out = eo;
        acc_ready = rdy;
        prev_busy = busy;
        prev_bi = il_bi;
        cyc++;
    endtask

    task automatic launch();
        clear_rec();
        cyc = 0;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
    endtask

    task automatic run_to_idle(input int limit);
        while (idle_cyc < 0 && cyc < limit) tick();
        total++;
        if (idle_cyc < 0) begin bad++; $display("FAIL run_budget got=busy exp=idle by cycle %0d", limit); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, il_en, acc_valid} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, err, il_en, acc_valid});
        end
        total++;
        if (il_bi !== '0 || acc_idx !== 6'd0) begin
            bad++; $display("FAIL reset_data got=%h/%0d exp=0/0", il_bi, acc_idx);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        prev_busy = 1'b0;
    endtask

    task automatic test_full_run_back_to_back();
        logic [SZ-1:0] b1, b2;
        b1 = '1; b2 = rand_b();
        b_v = b1;
        launch();
        b_v = b2;
        start_on_idle = 1'b1;
        run_to_idle(400);
        start_on_idle = 1'b0;
        total++;
        if (en_cyc.size() != ND) begin bad++; $display("FAIL full_en_count got=%0d exp=%0d", en_cyc.size(), ND); end
        for (int k = 0; k < ND && k < en_cyc.size(); k++) begin
            total++;
            if (en_cyc[k] != 1 + 6*k) begin bad++; $display("FAIL full_en_cycle k=%0d got=%0d exp=%0d", k, en_cyc[k], 1 + 6*k); end
            total++;
            if (en_bi[k] !== exp_digit(b1, k)) begin bad++; $display("FAIL full_bi k=%0d got=%h exp=%h", k, en_bi[k], exp_digit(b1, k)); end
        end
        for (int k = 0; k < ND && k < acc_q.size(); k++) begin
            total++;
            if (acc_q[k] != k) begin bad++; $display("FAIL full_acc_idx got=%0d exp=%0d", acc_q[k], k); end
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != 241) begin
            bad++; $display("FAIL full_done got=%0d pulses first=%0d exp=1 at 241", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        total++;
        if (idle_cyc != 242) begin bad++; $display("FAIL full_idle got=%0d exp=242", idle_cyc); end
        total++;
        if (bi_glitch != 0 || overlap != 0 || err !== 1'b0) begin
            bad++; $display("FAIL full_hygiene got=glitch%0d overlap%0d err%b exp=0 0 0", bi_glitch, overlap, err);
        end
        // Start sampled in the first IDLE cycle; this is cycle 0 of the second run.
        clear_rec();
        cyc = 1;
        run_to_idle(400);
        total++;
        if (en_cyc.size() != ND || en_cyc[0] != 1) begin
            bad++; $display("FAIL b2b_start got=%0d pulses first=%0d exp=%0d first=1", en_cyc.size(), (en_cyc.size() > 0) ? en_cyc[0] : -1, ND);
        end
        for (int k = 0; k < ND && k < en_bi.size(); k++) begin
            total++;
            if (en_bi[k] !== exp_digit(b2, k)) begin bad++; $display("FAIL b2b_bi k=%0d got=%h exp=%h", k, en_bi[k], exp_digit(b2, k)); end
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != 241) begin bad++; $display("FAIL b2b_done got=%0d pulses exp=1 at 241", done_cyc.size()); end
    endtask

    task automatic test_backpressure_and_ignored();
        logic [SZ-1:0] b1;
        b1 = rand_b();
        b_v = b1;
        stall_digit = 5; stall_left = 3; spur_on = 1'b1;
        launch();
        while (cyc < 20) tick();
        start_v = 1'b1; b_v = rand_b();
        repeat (3) tick();
        start_v = 1'b0;
        run_to_idle(400);
        spur_on = 1'b0; stall_digit = -1;
        total++;
        if (acc_hold[5] != 4) begin bad++; $display("FAIL bp_hold got=%0d exp=4", acc_hold[5]); end
        total++;
        if (en_cyc.size() != ND || en_cyc[6] != 40 || en_cyc[5] != 31) begin
            bad++; $display("FAIL bp_issue got=%0d pulses d6=%0d exp=%0d d6=40", en_cyc.size(), (en_cyc.size() > 6) ? en_cyc[6] : -1, ND);
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != 244) begin
            bad++; $display("FAIL bp_done got=%0d first=%0d exp=1 at 244", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        total++;
        if (bi_glitch != 0) begin bad++; $display("FAIL bp_bi_stable got=%0d exp=0", bi_glitch); end
        for (int k = 0; k < ND && k < en_bi.size(); k++) begin
            total++;
            if (en_bi[k] !== exp_digit(b1, k)) begin bad++; $display("FAIL bp_blatch k=%0d got=%h exp=%h", k, en_bi[k], exp_digit(b1, k)); end
        end
    endtask

    task automatic test_timeout();
        b_v = rand_b();
        hang_digit = 2;
        launch();
        run_to_idle(200);
        hang_digit = -1;
        total++;
        if (idle_cyc != 22) begin bad++; $display("FAIL to_idle got=%0d exp=22", idle_cyc); end
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", err); end
        total++;
        if (done_cyc.size() != 0 || en_cyc.size() != 3 || acc_q.size() != 2) begin
            bad++; $display("FAIL to_events got=done%0d en%0d acc%0d exp=0 3 2", done_cyc.size(), en_cyc.size(), acc_q.size());
        end
        launch();
        tick();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL to_err_clear got=%b exp=0", err); end
        run_to_idle(400);
        total++;
        if (done_cyc.size() != 1 || en_cyc.size() != ND) begin bad++; $display("FAIL to_rerun got=done%0d en%0d exp=1 %0d", done_cyc.size(), en_cyc.size(), ND); end
    endtask

    task automatic test_en_out_at_timeout();
        b_v = rand_b();
        slow_digit = 3;
        launch();
        run_to_idle(400);
        slow_digit = -1;
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL race_err got=%b exp=0", err); end
        total++;
        if (en_cyc.size() != ND || en_cyc[4] != 29) begin
            bad++; $display("FAIL race_issue got=%0d d4=%0d exp=%0d d4=29", en_cyc.size(), (en_cyc.size() > 4) ? en_cyc[4] : -1, ND);
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != 245) begin bad++; $display("FAIL race_done got=%0d exp=1 at 245", done_cyc.size()); end
    endtask

    task automatic test_abort();
        logic [SZ-1:0] b2;
        b_v = rand_b();
        launch();
        while (en_cyc.size() < 11 && cyc < 200) tick();
        abort_v = 1'b1;
        tick();
        abort_v = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || idle_cyc != 63) begin bad++; $display("FAIL abort_idle got=busy%b at %0d exp=0 at 63", busy, idle_cyc); end
        repeat (20) tick();
        total++;
        if (en_cyc.size() != 11 || done_cyc.size() != 0 || err !== 1'b0) begin
            bad++; $display("FAIL abort_quiet got=en%0d done%0d err%b exp=11 0 0", en_cyc.size(), done_cyc.size(), err);
        end
        b2 = rand_b();
        b_v = b2;
        launch();
        run_to_idle(400);
        total++;
        if (en_cyc.size() != ND || en_bi[0] !== exp_digit(b2, 0) || acc_q[0] != 0) begin
            bad++; $display("FAIL abort_restart got=en%0d bi0=%h exp=%0d bi0=%h", en_cyc.size(), en_bi[0], ND, exp_digit(b2, 0));
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != 241) begin bad++; $display("FAIL abort_done got=%0d exp=1 at 241", done_cyc.size()); end
    endtask

    task automatic test_async_reset();
        b_v = rand_b();
        launch();
        while (!(acc_valid === 1'b1 && acc_idx == 6'd20) && cyc < 300) tick();
        total++;
        if (cyc != 127) begin bad++; $display("FAIL ar_reach got=%0d exp=127", cyc); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, il_en, acc_valid} !== 5'b0 || il_bi !== '0 || acc_idx !== 6'd0) begin
            bad++; $display("FAIL ar_outputs got=%b/%h/%0d exp=00000/0/0", {busy, done, err, il_en, acc_valid}, il_bi, acc_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_busy = 1'b0;
        il_pend = 0;
        b_v = rand_b();
        launch();
        run_to_idle(400);
        total++;
        if (en_cyc.size() != ND || done_cyc.size() != 1 || acc_q.size() != ND) begin
            bad++; $display("FAIL ar_rerun got=en%0d done%0d acc%0d exp=%0d 1 %0d", en_cyc.size(), done_cyc.size(), acc_q.size(), ND, ND);
        end
    endtask

    initial begin
        test_reset();
        test_full_run_back_to_back();
        test_backpressure_and_ignored();
        test_timeout();
        test_en_out_at_timeout();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
